// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone constants for the external tile arbiter.
//   wb_arb_state_t : arbiter FSM state
//   WB_CTI_*       : Wishbone B3 cycle type identifiers
//   WB_BTE_*       : Wishbone B3 burst type extensions
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    ABORT
  } wb_arb_state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_CONST   = 3'b001;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
  localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
  localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
  localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_ext_tile_arbiter_arb_rr.sv
// Combinational round-robin picker.
//   req : request vector
//   cur : one-hot position of the last owner; search starts just above it
//   gnt : one-hot winner, all-zero when req is empty
module arb_rr #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] cur,
  output logic [N-1:0] gnt
);

  logic [N-1:0] above;  // positions strictly above the last owner
  logic [N-1:0] hi_req;
  logic         found;
  logic         unused_cur_msb;

  // The top position can never be below another, so its pointer bit is not needed.
  assign unused_cur_msb = cur[N-1];

  always_comb begin
    above = '0;
    for (int t = 1; t < N; t++) begin
      above[t] = above[t-1] | cur[t-1];
    end
    hi_req = req & above;
  end

  // Lowest request above the pointer wins; otherwise wrap to the lowest request overall.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int t = 0; t < N; t++) begin
      if (!found && hi_req[t]) begin
        gnt[t] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int t = 0; t < N; t++) begin
      if (!found && req[t]) begin
        gnt[t] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ext_tile_arbiter.sv
// Merges NUM_TILES tile-side Wishbone masters onto one external slave port.
// Round-robin arbitration, bus held for a whole cyc (bursts preserved), per-transfer timeout.
//   clk, rst                         : clock, asynchronous active-high reset
//   tile_*_i                         : packed per-tile master buses, tile t at slice t
//   tile_ack_o/rty_o/err_o           : per-tile responses (owner only)
//   tile_dat_o                       : read data broadcast to all tiles
//   ext_*_o / ext_*_i                : shared master port toward the slave
//   grant_o                          : one-hot current owner, zero when idle
//   timeout_o                        : one-cycle pulse per timeout abort
module wb_ext_tile_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_TILES  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_TILES*ADDR_WIDTH-1:0]   tile_adr_i,
  input  logic [NUM_TILES*DATA_WIDTH-1:0]   tile_dat_i,
  input  logic [NUM_TILES*DATA_WIDTH/8-1:0] tile_sel_i,
  input  logic [NUM_TILES-1:0]              tile_cyc_i,
  input  logic [NUM_TILES-1:0]              tile_stb_i,
  input  logic [NUM_TILES-1:0]              tile_we_i,
  input  logic [NUM_TILES-1:0]              tile_cab_i,
  input  logic [NUM_TILES*3-1:0]            tile_cti_i,
  input  logic [NUM_TILES*2-1:0]            tile_bte_i,
  output logic [NUM_TILES-1:0]              tile_ack_o,
  output logic [NUM_TILES-1:0]              tile_rty_o,
  output logic [NUM_TILES-1:0]              tile_err_o,
  output logic [DATA_WIDTH-1:0]             tile_dat_o,
  output logic [ADDR_WIDTH-1:0]             ext_adr_o,
  output logic [DATA_WIDTH-1:0]             ext_dat_o,
  output logic [DATA_WIDTH/8-1:0]           ext_sel_o,
  output logic                              ext_cyc_o,
  output logic                              ext_stb_o,
  output logic                              ext_we_o,
  output logic                              ext_cab_o,
  output logic [2:0]                        ext_cti_o,
  output logic [1:0]                        ext_bte_o,
  input  logic                              ext_ack_i,
  input  logic                              ext_rty_i,
  input  logic                              ext_err_i,
  input  logic [DATA_WIDTH-1:0]             ext_dat_i,
  output logic [NUM_TILES-1:0]              grant_o,
  output logic                              timeout_o
);

  localparam int unsigned SelW = DATA_WIDTH / 8;
  // Pointer parked on the top tile so tile 0 has first priority out of reset.
  localparam logic [NUM_TILES-1:0] PtrRst = NUM_TILES'(1) << (NUM_TILES - 1);

  wb_arb_state_t state_q, state_d;
  logic [NUM_TILES-1:0] grant_q, grant_d;
  logic [NUM_TILES-1:0] ptr_q, ptr_d;
  logic [NUM_TILES-1:0] arb_req, arb_gnt;
  logic                 cnt_inc, expire;

  logic [ADDR_WIDTH-1:0] mux_adr;
  logic [DATA_WIDTH-1:0] mux_dat;
  logic [SelW-1:0]       mux_sel;
  logic [2:0]            mux_cti;
  logic [1:0]            mux_bte;
  logic                  own_cyc, own_stb, own_we, own_cab;
  logic                  resp;

  assign tile_dat_o = ext_dat_i;
  assign grant_o    = grant_q;
  assign resp       = ext_ack_i | ext_rty_i | ext_err_i;
  // The releasing owner is never a candidate, so nobody is granted twice while another waits.
  assign arb_req    = tile_cyc_i & ~grant_q;

  arb_rr #(
    .N (NUM_TILES)
  ) u_arb_rr (
    .req (arb_req),
    .cur (ptr_q),
    .gnt (arb_gnt)
  );

  // Owner's bus selected by AND-OR over the one-hot grant.
  always_comb begin
    mux_adr = '0;
    mux_dat = '0;
    mux_sel = '0;
    mux_cti = '0;
    mux_bte = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      if (grant_q[t]) begin
        mux_adr |= tile_adr_i[t*ADDR_WIDTH +: ADDR_WIDTH];
        mux_dat |= tile_dat_i[t*DATA_WIDTH +: DATA_WIDTH];
        mux_sel |= tile_sel_i[t*SelW +: SelW];
        mux_cti |= tile_cti_i[t*3 +: 3];
        mux_bte |= tile_bte_i[t*2 +: 2];
      end
    end
    own_cyc = |(grant_q & tile_cyc_i);
    own_stb = |(grant_q & tile_stb_i);
    own_we  = |(grant_q & tile_we_i);
    own_cab = |(grant_q & tile_cab_i);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_inc    = 1'b0;
    timeout_o  = 1'b0;
    tile_ack_o = '0;
    tile_rty_o = '0;
    tile_err_o = '0;
    ext_adr_o  = '0;
    ext_dat_o  = '0;
    ext_sel_o  = '0;
    ext_cyc_o  = 1'b0;
    ext_stb_o  = 1'b0;
    ext_we_o   = 1'b0;
    ext_cab_o  = 1'b0;
    ext_cti_o  = '0;
    ext_bte_o  = '0;

    // Arbitration result is shared by the idle start and by release from OWNED/ABORT.
    if ((state_q == IDLE) || !own_cyc) begin
      grant_d = arb_gnt;
      if (|arb_gnt) begin
        ptr_d   = arb_gnt;
        state_d = OWNED;
      end else begin
        state_d = IDLE;
      end
    end

    if ((state_q == OWNED) && own_cyc) begin
      ext_adr_o = mux_adr;
      ext_dat_o = mux_dat;
      ext_sel_o = mux_sel;
      ext_we_o  = own_we;
      ext_cab_o = own_cab;
      ext_cti_o = mux_cti;
      ext_bte_o = mux_bte;
      if (own_stb && !resp && expire) begin
        tile_err_o = grant_q;
        timeout_o  = 1'b1;
        state_d    = ABORT;
      end else begin
        ext_cyc_o  = 1'b1;
        ext_stb_o  = own_stb;
        tile_ack_o = grant_q & {NUM_TILES{ext_ack_i}};
        tile_rty_o = grant_q & {NUM_TILES{ext_rty_i}};
        tile_err_o = grant_q & {NUM_TILES{ext_err_i}};
        cnt_inc    = own_stb && !resp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PtrRst;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  if (TIMEOUT > 0) begin : g_timeout
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end

    assign expire = (cnt_q == CntW'(TIMEOUT - 1));
  end else begin : g_no_timeout
    logic unused_cnt_inc;
    assign unused_cnt_inc = cnt_inc;
    assign expire         = 1'b0;
  end

endmodule

// File: tb/tb_wb_ext_tile_arbiter.sv
module tb_wb_ext_tile_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned NT = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NT*AW-1:0]  tile_adr_i;
  logic [NT*DW-1:0]  tile_dat_i;
  logic [NT*DW/8-1:0] tile_sel_i;
  logic [NT-1:0]     tile_cyc_i, tile_stb_i, tile_we_i, tile_cab_i;
  logic [NT*3-1:0]   tile_cti_i;
  logic [NT*2-1:0]   tile_bte_i;
  logic [NT-1:0]     tile_ack_o, tile_rty_o, tile_err_o;
  logic [DW-1:0]     tile_dat_o;
  logic [AW-1:0]     ext_adr_o;
  logic [DW-1:0]     ext_dat_o;
  logic [DW/8-1:0]   ext_sel_o;
  logic              ext_cyc_o, ext_stb_o, ext_we_o, ext_cab_o;
  logic [2:0]        ext_cti_o;
  logic [1:0]        ext_bte_o;
  logic              ext_ack_i, ext_rty_i, ext_err_i;
  logic [DW-1:0]     ext_dat_i;
  logic [NT-1:0]     grant_o;
  logic              timeout_o;

  always #5 clk = ~clk;

  wb_ext_tile_arbiter #(
    .NUM_TILES  (NT),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tile_adr_i (tile_adr_i),
    .tile_dat_i (tile_dat_i),
    .tile_sel_i (tile_sel_i),
    .tile_cyc_i (tile_cyc_i),
    .tile_stb_i (tile_stb_i),
    .tile_we_i  (tile_we_i),
    .tile_cab_i (tile_cab_i),
    .tile_cti_i (tile_cti_i),
    .tile_bte_i (tile_bte_i),
    .tile_ack_o (tile_ack_o),
    .tile_rty_o (tile_rty_o),
    .tile_err_o (tile_err_o),
    .tile_dat_o (tile_dat_o),
    .ext_adr_o  (ext_adr_o),
    .ext_dat_o  (ext_dat_o),
    .ext_sel_o  (ext_sel_o),
    .ext_cyc_o  (ext_cyc_o),
    .ext_stb_o  (ext_stb_o),
    .ext_we_o   (ext_we_o),
    .ext_cab_o  (ext_cab_o),
    .ext_cti_o  (ext_cti_o),
    .ext_bte_o  (ext_bte_o),
    .ext_ack_i  (ext_ack_i),
    .ext_rty_i  (ext_rty_i),
    .ext_err_i  (ext_err_i),
    .ext_dat_i  (ext_dat_i),
    .grant_o    (grant_o),
    .timeout_o  (timeout_o)
  );

  // One record per clock cycle: stimulus, then the outputs expected in that same cycle.
  typedef struct {
    logic       rst;
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] gnt;
    logic [3:0] tack;
    logic [3:0] terr;
    logic       ecyc;
    logic       to;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] c, input logic a,
                              input logic [3:0] g, input logic [3:0] ta,
                              input logic [3:0] te, input logic ec, input logic t);
    vec_t v;
    v.rst = r; v.cyc = c; v.ack = a; v.gnt = g; v.tack = ta; v.terr = te; v.ecyc = ec; v.to = t;
    return v;
  endfunction

  function automatic logic [31:0] adr_of(input int t);
    return (32'(t + 1) << 28) | (32'(t) << 6);
  endfunction

  function automatic logic [2:0] cti_of(input int t);
    return (t == 1) ? WB_CTI_INCR : WB_CTI_CLASSIC;
  endfunction

  function automatic logic [31:0] exp_adr(input logic [3:0] g);
    logic [31:0] r;
    r = '0;
    for (int t = 0; t < 4; t++) if (g[t]) r |= adr_of(t);
    return r;
  endfunction

  function automatic logic [2:0] exp_cti(input logic [3:0] g);
    logic [2:0] r;
    r = '0;
    for (int t = 0; t < 4; t++) if (g[t]) r |= cti_of(t);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string nm, input int idx);
    chk({nm, "_grant"}, idx, 32'(grant_o), 32'h0);
    chk({nm, "_ext_cyc"}, idx, 32'(ext_cyc_o), 32'h0);
    chk({nm, "_ext_adr"}, idx, ext_adr_o, 32'h0);
    chk({nm, "_tile_ack"}, idx, 32'(tile_ack_o), 32'h0);
    chk({nm, "_timeout"}, idx, 32'(timeout_o), 32'h0);
  endtask

  task automatic add_wait7(input logic [3:0] c, input logic [3:0] g);
    for (int k = 0; k < 7; k++) vq.push_back(mk(0, c, 0, g, 4'h0, 4'h0, 1, 0));
  endtask

  initial begin
    tile_dat_i = '0;
    tile_sel_i = '1;
    tile_cyc_i = '0;
    tile_stb_i = '0;
    tile_we_i  = 4'b1010;
    tile_cab_i = '0;
    tile_bte_i = '0;
    ext_ack_i  = 1'b0;
    ext_rty_i  = 1'b0;
    ext_err_i  = 1'b0;
    ext_dat_i  = '0;
    for (int t = 0; t < NT; t++) begin
      tile_adr_i[t*AW +: AW] = adr_of(t);
      tile_cti_i[t*3 +: 3]   = cti_of(t);
    end

    // Single read on tile 2, acked three cycles after cyc.
    vq.push_back(mk(1, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0100, 0, 4'b0100, 4'b0000, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b0100, 0, 4'b0100, 4'b0000, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    // All tiles contend; order 0,1,2,3,0 with one dead ext cycle per handover.
    vq.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1111, 1, 4'b0001, 4'b0001, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b1110, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1110, 1, 4'b0010, 4'b0010, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b1100, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1100, 1, 4'b0100, 4'b0100, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b1001, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1001, 1, 4'b1000, 4'b1000, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b0001, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    // Tile 1 four-beat burst holds the bus while tile 3 waits.
    vq.push_back(mk(1, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1010, 0, 4'b0010, 4'b0000, 4'b0000, 1, 0));
    for (int k = 0; k < 4; k++) vq.push_back(mk(0, 4'b1010, 1, 4'b0010, 4'b0010, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b1000, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1000, 0, 4'b1000, 4'b0000, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    // Timeout on tile 0: err on the 8th stb cycle, late ack swallowed in ABORT.
    vq.push_back(mk(1, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    add_wait7(4'b0001, 4'b0001);
    vq.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0001, 0, 1));
    vq.push_back(mk(0, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    // Ack on the expiry cycle wins over the timeout.
    vq.push_back(mk(1, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    add_wait7(4'b0001, 4'b0001);
    vq.push_back(mk(0, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0000, 1, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));

    #2;
    chk_reset_state("init_reset", -1);
    #1 rst = 1'b0;

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      if (vq[i].rst) begin
        rst = 1'b1;
        #1;
        chk_reset_state("vec_reset", i);
        rst = 1'b0;
      end
      tile_cyc_i = vq[i].cyc;
      tile_stb_i = vq[i].cyc;
      ext_ack_i  = vq[i].ack;
      ext_dat_i  = 32'hD000_0000 | 32'(i);
      @(negedge clk);
      chk("grant", i, 32'(grant_o), 32'(vq[i].gnt));
      chk("tile_ack", i, 32'(tile_ack_o), 32'(vq[i].tack));
      chk("tile_err", i, 32'(tile_err_o), 32'(vq[i].terr));
      chk("tile_rty", i, 32'(tile_rty_o), 32'h0);
      chk("ext_cyc", i, 32'(ext_cyc_o), 32'(vq[i].ecyc));
      chk("ext_stb", i, 32'(ext_stb_o), 32'(vq[i].ecyc));
      chk("timeout", i, 32'(timeout_o), 32'(vq[i].to));
      chk("tile_dat", i, tile_dat_o, 32'hD000_0000 | 32'(i));
      if (vq[i].ecyc) begin
        chk("ext_adr", i, ext_adr_o, exp_adr(vq[i].gnt));
        chk("ext_cti", i, 32'(ext_cti_o), 32'(exp_cti(vq[i].gnt)));
        chk("ext_we", i, 32'(ext_we_o), 32'(|(vq[i].gnt & 4'b1010)));
      end
    end

    // Reset asserted mid-burst on tile 2, then tile 0 wins a 0/2 tie.
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tile_cyc_i = 4'b0100;
    tile_stb_i = 4'b0100;
    @(posedge clk);
    #1;
    tile_cyc_i = 4'b0101;
    tile_stb_i = 4'b0101;
    ext_ack_i  = 1'b1;
    #1;
    chk("burst_grant", 100, 32'(grant_o), 32'b0100);
    chk("burst_ack", 100, 32'(tile_ack_o), 32'b0100);
    rst = 1'b1;
    #1;
    chk_reset_state("mid_burst_reset", 101);
    @(posedge clk);
    #1;
    chk_reset_state("held_reset", 102);
    rst = 1'b0;
    ext_ack_i = 1'b0;
    @(posedge clk);
    #1;
    chk("tie_grant", 103, 32'(grant_o), 32'b0001);
    chk("tie_ext_adr", 103, ext_adr_o, adr_of(0));
    tile_cyc_i = '0;
    tile_stb_i = '0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
